// File: rtl/mux_stream_nx1_if.sv
// Stream bundle between N producers, the multiplexer and one consumer.
//
// Handshake: a word moves across a channel on a rising edge where that
// channel's valid and ready are both high. A producer may hold valid for
// any number of cycles without ready, and the word stays unconsumed until
// ready is seen. The multiplexer raises at most one in_ready bit per cycle.
// On the output side, out_valid marks a held word and the consumer takes it
// in any cycle where out_ready is high.
interface mux_stream_nx1_if #(
  parameter int N = 8,
  parameter int W = 8
);
  localparam int SW = $clog2(N);

  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_chan;
  logic           out_valid;
  logic           out_ready;

  // Multiplexer side.
  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_chan,
    output out_valid,
    input  out_ready
  );

  // Producer/consumer side.
  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_chan,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/mux_stream_nx1.sv
// N-to-1 stream multiplexer with a registered output stage.
// mode = 0 forwards the channel named by sel; mode = 1 arbitrates round-robin
// among valid channels, starting the scan at rr_ptr.
module mux_stream_nx1 #(
  parameter  int N  = 8,
  parameter  int W  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mode,
  input  logic [SW-1:0] sel,
  mux_stream_nx1_if.slave bus
);

  logic [SW-1:0] rr_ptr;
  logic [SW-1:0] gnt;
  logic          gnt_valid;
  logic          load_ok;
  logic          xfer;

  // The output register can accept a word when empty or when it drains now.
  assign load_ok = !bus.out_valid || bus.out_ready;

  // A transfer happens whenever a grant exists and the output can take it;
  // the granted channel is valid by construction of the grant.
  assign xfer = gnt_valid && load_ok && !rst;

  // Grant selection: fixed channel check, or rotating priority scan.
  always_comb begin
    int idx;
    gnt_valid = 1'b0;
    gnt       = '0;
    idx       = 0;
    if (!mode) begin
      // sel may exceed N-1 when N is not a power of two; that is no grant.
      if (int'(sel) < N) begin
        if (bus.in_valid[sel]) begin
          gnt_valid = 1'b1;
          gnt       = sel;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        idx = int'(rr_ptr) + i;
        if (idx >= N) idx = idx - N;
        if (!gnt_valid && bus.in_valid[idx]) begin
          gnt_valid = 1'b1;
          gnt       = SW'(idx);
        end
      end
    end
  end

  // Ready goes only to the granted channel, and only if the word can land.
  always_comb begin
    bus.in_ready = '0;
    if (xfer) bus.in_ready = N'(1) << gnt;
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_chan  <= '0;
      rr_ptr        <= '0;
    end else begin
      if (xfer) begin
        bus.out_data  <= bus.in_data[gnt*W +: W];
        bus.out_chan  <= gnt;
        bus.out_valid <= 1'b1;
        // Pointer moves past the winner so it has lowest priority next time.
        if (mode) rr_ptr <= (gnt == SW'(N - 1)) ? '0 : gnt + 1'b1;
      end else if (bus.out_valid && bus.out_ready) begin
        // Drain with nothing to replace it; data and channel are left as is.
        bus.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_stream_nx1.sv
// Bench for mux_stream_nx1: an 8-channel instance driven from a vector table
// plus backpressure and reset sequences, and a 6-channel instance for the
// out-of-range select case.
module tb_mux_stream_nx1;

  typedef struct {
    logic       m;
    logic [2:0] s;
    logic [7:0] iv;
    logic       r;
    logic [7:0] rdy;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       mode;
  logic [2:0] sel;
  logic       mode6;
  logic [2:0] sel6;

  int total;
  int bad;

  logic [10:0] exp_q[$];
  vec_t        vecs[$];

  mux_stream_nx1_if #(.N(8), .W(8)) bus ();
  mux_stream_nx1_if #(.N(6), .W(8)) bus6 ();

  mux_stream_nx1 #(.N(8), .W(8)) u_dut (
    .clk  (clk),
    .rst  (rst),
    .mode (mode),
    .sel  (sel),
    .bus  (bus)
  );

  mux_stream_nx1 #(.N(6), .W(8)) u_dut6 (
    .clk  (clk),
    .rst  (rst),
    .mode (mode6),
    .sel  (sel6),
    .bus  (bus6)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic add(input logic m, input logic [2:0] s, input logic [7:0] iv,
                     input logic r, input logic [7:0] rdy);
    vec_t v;
    v.m = m; v.s = s; v.iv = iv; v.r = r; v.rdy = rdy;
    vecs.push_back(v);
  endtask

  // Output register against the scoreboard head.
  task automatic check_out(input string name);
    check({name, "/out_valid"}, 64'(bus.out_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0)
      check({name, "/out_word"}, 64'({bus.out_chan, bus.out_data}), 64'(exp_q[0]));
  endtask

  // One cycle: drive at posedge+1, check at negedge, advance the scoreboard.
  task automatic step(input logic m, input logic [2:0] s, input logic [7:0] iv,
                      input logic r, input logic [7:0] rdy, input string name);
    logic [63:0] din;
    logic [2:0]  ch;
    din           = {$urandom, $urandom};
    mode          = m;
    sel           = s;
    bus.in_valid  = iv;
    bus.out_ready = r;
    bus.in_data   = din;
    @(negedge clk);
    check_out(name);
    check({name, "/in_ready"}, 64'(bus.in_ready), 64'(rdy));
    if (exp_q.size() != 0 && r) void'(exp_q.pop_front());
    if (rdy != 8'h00) begin
      ch = 3'd0;
      for (int k = 0; k < 8; k++) if (rdy[k]) ch = 3'(k);
      exp_q.push_back({ch, din[ch*8 +: 8]});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [47:0] d6;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    mode  = 1'b0;
    sel   = 3'd0;
    mode6 = 1'b0;
    sel6  = 3'd0;
    bus.in_valid   = '0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b0;
    bus6.in_valid  = '0;
    bus6.in_data   = '0;
    bus6.out_ready = 1'b0;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset/out_valid", 64'(bus.out_valid), 64'd0);
    check("reset/out_data", 64'(bus.out_data), 64'd0);
    check("reset/out_chan", 64'(bus.out_chan), 64'd0);
    @(posedge clk);
    #1;

    // Vector table: mode, sel, in_valid, out_ready, expected in_ready
    add(1'b0, 3'd3, 8'h08, 1'b1, 8'h08);  // fixed sel=3
    add(1'b0, 3'd3, 8'hF7, 1'b1, 8'h00);  // sel channel idle, others valid
    add(1'b0, 3'd3, 8'hF7, 1'b1, 8'h00);
    add(1'b1, 3'd0, 8'hFF, 1'b1, 8'h01);  // RR full rotation from 0
    add(1'b1, 3'd0, 8'hFF, 1'b1, 8'h02);
    add(1'b1, 3'd0, 8'hFF, 1'b1, 8'h04);
    add(1'b1, 3'd0, 8'hFF, 1'b1, 8'h08);
    add(1'b1, 3'd0, 8'hFF, 1'b1, 8'h10);
    add(1'b1, 3'd0, 8'hFF, 1'b1, 8'h20);
    add(1'b1, 3'd0, 8'hFF, 1'b1, 8'h40);
    add(1'b1, 3'd0, 8'hFF, 1'b1, 8'h80);
    add(1'b1, 3'd0, 8'hFF, 1'b1, 8'h01);
    add(1'b1, 3'd0, 8'hFF, 1'b1, 8'h02);
    add(1'b1, 3'd0, 8'h24, 1'b1, 8'h04);  // RR between ch2 and ch5
    add(1'b1, 3'd0, 8'h24, 1'b1, 8'h20);
    add(1'b1, 3'd0, 8'h24, 1'b1, 8'h04);
    add(1'b1, 3'd0, 8'h24, 1'b1, 8'h20);
    add(1'b1, 3'd0, 8'h04, 1'b1, 8'h04);  // only ch2 left
    add(1'b1, 3'd0, 8'h04, 1'b1, 8'h04);
    add(1'b0, 3'd0, 8'h01, 1'b1, 8'h01);  // fixed, pointer untouched
    add(1'b1, 3'd0, 8'hFF, 1'b1, 8'h08);  // RR resumes at 3

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].m, vecs[i].s, vecs[i].iv, vecs[i].r, vecs[i].rdy, $sformatf("vec%0d", i));

    // Backpressure: word held, no ready, mode flip does not disturb it
    step(1'b1, 3'd0, 8'hFF, 1'b0, 8'h00, "bp0");
    step(1'b1, 3'd0, 8'hFF, 1'b0, 8'h00, "bp1");
    step(1'b0, 3'd5, 8'hFF, 1'b0, 8'h00, "bp2");
    step(1'b1, 3'd0, 8'hFF, 1'b0, 8'h00, "bp3");
    step(1'b1, 3'd0, 8'hFF, 1'b1, 8'h10, "bp_release");

    // Reset with a pending word and rr_ptr at 5
    rst           = 1'b1;
    mode          = 1'b1;
    bus.in_valid  = 8'hFF;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("rst_mid/in_ready", 64'(bus.in_ready), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 8'h00;
    @(negedge clk);
    check("rst_mid/out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_mid/out_data", 64'(bus.out_data), 64'd0);
    check("rst_mid/out_chan", 64'(bus.out_chan), 64'd0);
    @(posedge clk);
    #1;
    step(1'b1, 3'd0, 8'hFF, 1'b0, 8'h01, "post_rst_load");
    step(1'b1, 3'd0, 8'hFF, 1'b0, 8'h00, "post_rst_full");
    step(1'b1, 3'd0, 8'h00, 1'b1, 8'h00, "drain");
    step(1'b1, 3'd0, 8'h00, 1'b1, 8'h00, "empty");

    // Six channels: select beyond N-1 grants nothing
    d6             = {$urandom, $urandom};
    mode6          = 1'b0;
    sel6           = 3'd7;
    bus6.in_valid  = 6'h3F;
    bus6.out_ready = 1'b1;
    bus6.in_data   = d6;
    @(negedge clk);
    check("n6_sel7/in_ready", 64'(bus6.in_ready), 64'd0);
    check("n6_sel7/out_valid", 64'(bus6.out_valid), 64'd0);
    @(posedge clk);
    #1;
    check("n6_sel7/after", 64'(bus6.out_valid), 64'd0);
    sel6 = 3'd5;
    @(negedge clk);
    check("n6_sel5/in_ready", 64'(bus6.in_ready), 64'h20);
    @(posedge clk);
    #1;
    bus6.in_valid = 6'h00;
    @(negedge clk);
    check("n6_sel5/out_valid", 64'(bus6.out_valid), 64'd1);
    check("n6_sel5/out_chan", 64'(bus6.out_chan), 64'd5);
    check("n6_sel5/out_data", 64'(bus6.out_data), 64'(d6[47:40]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
